alu_sphere_sequencer: RTL and testbench

Micro-sequencer that drives the calculator ALU through a fixed five-step program to compute a scaled sphere volume, V ≈ (4·3141/3000)·r³, from a single radius operand. It owns the ALU's `inputP`/`inputQ`/`opCode` lanes for the duration of a run. It observes the ALU accumulator output and error code, and reports a one-cycle `done` pulse with the result and the first error seen. It sits between the Python-middleware command decoder (requester) and the ALU instance.

---
 rtl/calc_pkg.sv | 37 +++
 rtl/seq_prog_rom.sv | 42 ++++
 rtl/alu_sphere_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_sphere_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the ALU sphere-volume sequencer: ALU opcodes,
// program constants, sequencer states and ROM operand selectors.
package calc_pkg;

  localparam logic [3:0] OP_HOLD  = 4'b0000;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_RESET = 4'b1100;
  localparam logic [3:0] OP_EXP   = 4'b1111;

  localparam int unsigned K_PI   = 3141;
  localparam int unsigned K_FOUR = 4;
  localparam int unsigned K_DIV  = 3000;

  localparam logic [2:0] LAST_STEP = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_ERR
  } seq_state_e;

  typedef enum logic [2:0] {
    PSEL_ZERO,
    PSEL_RADIUS,
    PSEL_PI,
    PSEL_FOUR,
    PSEL_DIV
  } psel_e;

  typedef enum logic {
    QSEL_ZERO,
    QSEL_EXP
  } qsel_e;

endpackage

// File: rtl/seq_prog_rom.sv
// Combinational program ROM: maps the current step to the ALU opcode and the
// operand selectors; emits HOLD with zero operands whenever not enabled.
module seq_prog_rom
  import calc_pkg::*;
(
  input  logic       en_i,
  input  logic [2:0] step_i,
  output logic [3:0] op_o,
  output psel_e      psel_o,
  output qsel_e      qsel_o
);

  always_comb begin
    op_o   = OP_HOLD;
    psel_o = PSEL_ZERO;
    qsel_o = QSEL_ZERO;
    if (en_i) begin
      case (step_i)
        3'd0: op_o = OP_RESET;
        3'd1: begin
          op_o   = OP_EXP;
          psel_o = PSEL_RADIUS;
          qsel_o = QSEL_EXP;
        end
        3'd2: begin
          op_o   = OP_MUL;
          psel_o = PSEL_PI;
        end
        3'd3: begin
          op_o   = OP_MUL;
          psel_o = PSEL_FOUR;
        end
        3'd4: begin
          op_o   = OP_DIV;
          psel_o = PSEL_DIV;
        end
        default: op_o = OP_HOLD;
      endcase
    end
  end

endmodule

// File: rtl/alu_sphere_sequencer.sv
// Five-step ALU micro-sequencer computing (4*3141/3000)*r^3 via the shared ALU.
// Define SEQ_ERROR_ABORT_EN to abort the program on the first nonzero ALU error.
module alu_sphere_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int EXP_Q = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] radius,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       error,
  output logic [WIDTH-1:0] alu_p,
  output logic [WIDTH-1:0] alu_q,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [1:0]       alu_err
);

  seq_state_e       state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [WIDTH-1:0] radius_q, radius_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       error_q, error_d;
  logic             done_q, done_d;
  logic             abort_now;
  psel_e            psel;
  qsel_e            qsel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      radius_q <= '0;
      result_q <= '0;
      error_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      radius_q <= radius_d;
      result_q <= result_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    abort_now = 1'b0;
`ifdef SEQ_ERROR_ABORT_EN
    abort_now = (alu_err != 2'b00);
`endif
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    radius_d = radius_q;
    result_d = result_q;
    error_d  = error_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The done cycle is itself IDLE, so a start seen alongside done is dropped.
        if (start && !done_q) begin
          radius_d = radius;
          error_d  = 2'b00;
          step_d   = 3'd0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if ((alu_err != 2'b00) && (error_q == 2'b00)) begin
          error_d = alu_err;
        end
        if (abort_now) begin
          state_d = S_ERR;
        end else if (step_q == LAST_STEP) begin
          state_d = S_DONE;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_DONE, S_ERR: begin
        result_d = alu_out;
        done_d   = 1'b1;
        step_d   = 3'd0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  seq_prog_rom u_rom (
    .en_i   (state_q == S_RUN),
    .step_i (step_q),
    .op_o   (alu_op),
    .psel_o (psel),
    .qsel_o (qsel)
  );

  always_comb begin
    alu_p = '0;
    case (psel)
      PSEL_RADIUS: alu_p = radius_q;
      PSEL_PI:     alu_p = WIDTH'(K_PI);
      PSEL_FOUR:   alu_p = WIDTH'(K_FOUR);
      PSEL_DIV:    alu_p = WIDTH'(K_DIV);
      default:     alu_p = '0;
    endcase
  end

  assign alu_q  = (qsel == QSEL_EXP) ? WIDTH'(EXP_Q) : '0;
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign error  = error_q;

endmodule

// File: tb/tb_alu_sphere_sequencer.sv
// Scoreboard bench for alu_sphere_sequencer with a behavioural ALU and a
// closed-form volume reference; honours SEQ_ERROR_ABORT_EN when defined.
module tb_alu_sphere_sequencer;

`ifdef SEQ_ERROR_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] radius;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  error;
  logic [31:0] alu_p;
  logic [31:0] alu_q;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic [1:0]  alu_err;

  logic [31:0] acc;
  logic        inj_en;
  int          cyc;
  int          compared;
  int          mismatched;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  err;
    int          lat;
    bit          div;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];

  alu_sphere_sequencer #(.WIDTH(32), .EXP_Q(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .radius  (radius),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .error   (error),
    .alu_p   (alu_p),
    .alu_q   (alu_q),
    .alu_op  (alu_op),
    .alu_out (alu_out),
    .alu_err (alu_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pow32(input logic [31:0] b, input logic [31:0] e);
    logic [31:0] v;
    v = 32'd1;
    for (int i = 0; i < 64; i++) begin
      if (i < int'(e)) v = v * b;
    end
    return v;
  endfunction

  // Environment model of the calculator ALU: registered accumulator.
  initial acc = 32'd0;
  always @(posedge clk) begin
    case (alu_op)
      4'b1100: acc <= 32'd0;
      4'b1111: acc <= pow32(alu_p, alu_q);
      4'b0010: acc <= acc * alu_p;
      4'b0011: acc <= (alu_p == 32'd0) ? acc : acc / alu_p;
      default: acc <= acc;
    endcase
  end
  assign alu_out = acc;
  assign alu_err = (inj_en && alu_op == 4'b0010 && alu_p == 32'd3141) ? 2'b01 : 2'b00;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected volume: r^3 * 3141 * 4 / 3000 in 32-bit wrapping arithmetic,
  // or r^3 * 3141 when the run aborts on the injected step-2 error.
  function automatic logic [31:0] ref_vol(input logic [31:0] r, input bit inj);
    logic [31:0] c;
    c = r * r;
    c = c * r;
    c = c * 32'd3141;
    if (ABORT && inj) return c;
    c = c * 32'd4;
    return c / 32'd3000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},   busy,   0);
    chk({tag, "_done"},   done,   0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_error"},  error,  0);
    chk({tag, "_alu_op"}, alu_op, 0);
    chk({tag, "_alu_p"},  alu_p,  0);
    chk({tag, "_alu_q"},  alu_q,  0);
  endtask

  task automatic do_run(input logic [31:0] r, input bit inj, input bit extra);
    exp_t e;
    @(negedge clk);
    start     = 1'b1;
    radius    = r;
    inj_en    = inj;
    e.res     = ref_vol(r, inj);
    e.err     = inj ? 2'b01 : 2'b00;
    e.lat     = (ABORT && inj) ? 4 : 6;
    e.div     = !(ABORT && inj);
    e.acc_cyc = cyc + 1;
    exp_q.push_back(e);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start  = extra && (k == 2 || k == 6 || k == 7);
      radius = $urandom;
    end
    if (start) begin
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 40 && (busy || done); i++) @(negedge clk);
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin
    int   busy_cnt;
    bit   div_seen;
    exp_t e;
    busy_cnt = 0;
    div_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
        div_seen = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        if (alu_op == 4'b0011) div_seen = 1'b1;
        if (done) begin
          chk("pending_at_done", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("result",      result,          e.res);
            chk("error",       error,           e.err);
            chk("latency",     cyc - e.acc_cyc, e.lat);
            chk("busy_cycles", busy_cnt,        e.lat);
            chk("div_issued",  div_seen,        e.div);
          end
          busy_cnt = 0;
          div_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [31:0] r;
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    radius     = 32'd0;
    inj_en     = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_run(32'd5, 1'b0, 1'b0);
    do_run(32'd10, 1'b0, 1'b0);
    do_run(32'd0, 1'b0, 1'b0);
    do_run(32'd5, 1'b1, 1'b0);
    do_run(32'd7, 1'b0, 1'b1);

    // Reset while step 3 is being presented.
    @(negedge clk);
    start  = 1'b1;
    radius = 32'd9;
    inj_en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("step3_op", alu_op, 4'b0010);
    chk("step3_p",  alu_p,  32'd4);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_run(32'd5, 1'b0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      r = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 60)) : $urandom;
      do_run(r, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
